mem_dump_arbiter: RTL
=====================

MEM_DUMP_ARBITER -- requirements
Module: mem_dump_arbiter

Interface
REQ-001 Parameters: ADDR_WIDTH, default 8, data RAM word-address width; LAST_ADDR, default 255, last word address dumped.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 pipeAddr  input  ADDR_WIDTH  MEM-stage RAM address (ALU result, low bits).
REQ-005 pipeWe  input  4  MEM-stage byte write enables.
REQ-006 pipeWriteData  input  32  MEM-stage store data.
REQ-007 pipeEnable  input  1  pipeline advance enable from the debug unit; 0 = pipeline frozen.
REQ-008 dumpStart  input  1  one-cycle request to dump the whole data RAM over UART.
REQ-009 ramDout  input  32  RAM read data, valid one cycle after the address is presented.
REQ-010 txFull  input  1  UART transmit FIFO full.
REQ-011 ramAddr  output  ADDR_WIDTH  RAM address.
REQ-012 ramWe  output  4  RAM byte write enables.
REQ-013 ramDin  output  32  RAM write data.
REQ-014 uartData  output  8  byte pushed to the UART transmit FIFO.
REQ-015 uartWrite  output  1  one-cycle push strobe for uartData.
REQ-016 grantDebug  output  1  1 = dumper owns the RAM port.
REQ-017 dumpBusy  output  1  1 from dumpStart acceptance to the end of DONE.
REQ-018 dumpDone  output  1  one-cycle pulse after the last byte is pushed.
REQ-019 conflict  output  1  sticky flag: a pipeline write was dropped during a dump.

Function
REQ-020 States: IDLE, WAIT_FREEZE, ADDR, READ, CAPTURE, SEND, DONE.
REQ-021 When grantDebug=0: ramAddr=pipeAddr, ramWe=pipeWe, ramDin=pipeWriteData, combinationally.
REQ-022 When grantDebug=1: ramAddr=word counter, ramWe=0, ramDin=0.
REQ-023 IDLE: on dumpStart=1, go to ADDR if pipeEnable=0, otherwise go to WAIT_FREEZE; set dumpBusy=1 and clear the word counter.
REQ-024 WAIT_FREEZE: grantDebug=0; go to ADDR on the first cycle with pipeEnable=0.
REQ-025 grantDebug=1 in ADDR, READ, CAPTURE, SEND and DONE only.
REQ-026 ADDR presents the counter; READ waits one cycle for RAM latency; CAPTURE registers ramDout into a 32-bit word buffer and clears the byte index.
REQ-027 SEND: on each cycle with txFull=0, set uartData=buffer byte, most-significant byte first ([31:24], [23:16], [15:8], [7:0]), assert uartWrite=1 and increment the byte index.
REQ-028 SEND with txFull=1: uartWrite=0 and the state holds; no byte is lost or repeated.
REQ-029 After byte index 3 is pushed: if the counter equals LAST_ADDR go to DONE, otherwise increment the counter and go to ADDR.
REQ-030 The counter never wraps; exactly (LAST_ADDR+1)*4 bytes are pushed per dump.
REQ-031 DONE: assert dumpDone=1 for one cycle, then go to IDLE with dumpBusy=0.
REQ-032 dumpStart outside IDLE is ignored; there is no queued second dump.
REQ-033 pipeWe!=0 while grantDebug=1 is dropped (never reaches the RAM) and sets conflict=1; conflict clears only on reset.
REQ-034 pipeEnable returning to 1 mid-dump does not abort the dump.
REQ-035 Minimum latency: with pipeEnable=0 and txFull=0, dumpStart at cycle 0 gives grantDebug=1 from cycle 1 and the first uartWrite at cycle 4.

Reset
REQ-036 Reset state: IDLE; counter, byte index and buffer = 0; uartData=0, uartWrite=0, grantDebug=0, dumpBusy=0, dumpDone=0, conflict=0.
REQ-037 Reset asserted mid-dump aborts immediately: no further uartWrite, and the RAM port returns to the pipeline in the same cycle.

Verification
REQ-038 RAM[0]=0x11223344, RAM[1]=0xAABBCCDD, pipeEnable=0, dumpStart -> uartData sequence 11,22,33,44,AA,BB,CC,DD, ... ; 1024 strobes total; dumpDone one cycle after the last strobe.
REQ-039 pipeEnable=1 during dumpStart, dropped to 0 ten cycles later -> grantDebug stays 0 for those ten cycles and pipeline writes land in RAM; dump starts on the first cycle with pipeEnable=0.
REQ-040 txFull held at 1 for 5 cycles during the SEND of word 3 -> no strobe in those cycles, then bytes resume in order with no duplicate or missing byte.
REQ-041 pipeWe=4'hF to address 0x10 during a dump -> RAM[0x10] unchanged, conflict=1 until reset.
REQ-042 Reset pulse at byte 500 -> uartWrite=0 at once and all outputs at reset values; a new dumpStart restarts from address 0.
REQ-043 dumpStart pulsed again mid-dump -> ignored; the byte count stays 1024 and there is exactly one dumpDone.

Source files
------------

// File: rtl/mem_dump_arbiter.sv
// Shares one data-RAM port between the pipeline MEM stage and a dumper that
// streams every word out over the UART, MSB first. The dumper takes the port only while it is busy.
module mem_dump_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int LAST_ADDR  = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pipeAddr,
    input  logic [3:0]            pipeWe,
    input  logic [31:0]           pipeWriteData,
    input  logic                  pipeEnable,
    input  logic                  dumpStart,
    input  logic [31:0]           ramDout,
    input  logic                  txFull,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [3:0]            ramWe,
    output logic [31:0]           ramDin,
    output logic [7:0]            uartData,
    output logic                  uartWrite,
    output logic                  grantDebug,
    output logic                  dumpBusy,
    output logic                  dumpDone,
    output logic                  conflict
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FREEZE,
        ADDR,
        READ,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = LAST_ADDR[ADDR_WIDTH-1:0];

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] word_cnt_reg, word_cnt_next;
    logic [1:0]            byte_idx_reg, byte_idx_next;
    logic [31:0]           buffer_reg, buffer_next;
    logic                  conflict_reg;
    logic                  grant;
    logic                  send_fire;
    logic [7:0]            buffer_bytes [4];

    // Byte 0 is the most significant byte, so the byte index walks MSB first.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign buffer_bytes[gi] = buffer_reg[31-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            word_cnt_reg <= '0;
            byte_idx_reg <= '0;
            buffer_reg   <= '0;
            conflict_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
            byte_idx_reg <= byte_idx_next;
            buffer_reg   <= buffer_next;
            if (grant && (pipeWe != 4'b0000)) begin
                conflict_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        byte_idx_next = byte_idx_reg;
        buffer_next   = buffer_reg;
        send_fire     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dumpStart) begin
                    word_cnt_next = '0;
                    state_next    = pipeEnable ? WAIT_FREEZE : ADDR;
                end
            end
            WAIT_FREEZE: begin
                if (!pipeEnable) begin
                    state_next = ADDR;
                end
            end
            ADDR:    state_next = READ;
            READ:    state_next = CAPTURE;
            CAPTURE: begin
                buffer_next   = ramDout;
                byte_idx_next = 2'd0;
                state_next    = SEND;
            end
            SEND: begin
                // A full FIFO simply holds the state; the index only moves on a push.
                if (!txFull) begin
                    send_fire = 1'b1;
                    if (byte_idx_reg == 2'd3) begin
                        if (word_cnt_reg == LAST_WORD) begin
                            state_next = DONE;
                        end else begin
                            word_cnt_next = word_cnt_reg + ADDR_WIDTH'(1);
                            state_next    = ADDR;
                        end
                    end else begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign grant = (state_reg == ADDR) || (state_reg == READ) || (state_reg == CAPTURE) ||
                   (state_reg == SEND) || (state_reg == DONE);

    // Port mux is combinational from state so an asynchronous reset hands the
    // RAM back to the pipeline in the same cycle.
    assign ramAddr    = grant ? word_cnt_reg : pipeAddr;
    assign ramWe      = grant ? 4'b0000 : pipeWe;
    assign ramDin     = grant ? 32'h0 : pipeWriteData;

    assign uartWrite  = send_fire;
    assign uartData   = send_fire ? buffer_bytes[byte_idx_reg] : 8'h00;
    assign grantDebug = grant;
    assign dumpBusy   = (state_reg != IDLE);
    assign dumpDone   = (state_reg == DONE);
    assign conflict   = conflict_reg;

endmodule
